axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- NM-input, one-output AXI-Stream arbiter with packet awareness and round-robin fairness.
- Acts as the merge stage feeding a single downstream consumer, such as a stream broadcaster. It collects packets from several producers onto one stream.
- A grant is held from the first beat of a packet through its TLAST beat, so packets are never interleaved.
- The output is fully registered.

Parameters:
- C_AXIS_DATA_WIDTH, 16, TDATA width in bits.
- NM, 4, number of slave (input) ports; minimum 2.
- LGNM, $clog2(NM), width of the grant index; derived, do not override.

Ports:
- S_AXI_ACLK  input  1  single clock; all logic on the rising edge.
- S_AXI_ARESETN  input  1  asynchronous, active-low reset.
- S_AXIS_TVALID  input  NM  per-port valid.
- S_AXIS_TREADY  output  NM  per-port ready.
- S_AXIS_TDATA  input  NM*C_AXIS_DATA_WIDTH  port k occupies bits [k*DW +: DW].
- S_AXIS_TLAST  input  NM  per-port end of packet.
- M_AXIS_TVALID  output  1  output valid (registered).
- M_AXIS_TREADY  input  1  output ready.
- M_AXIS_TDATA  output  C_AXIS_DATA_WIDTH  output data (registered).
- M_AXIS_TLAST  output  1  output end of packet (registered).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, grant=NM-1 (so port 0 wins first), M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, S_AXIS_TREADY=0.
- Reset mid-packet: the packet is abandoned and any registered beat is dropped. Upstream handshake rules are the sources' concern.
- State IDLE:
  - All S_AXIS_TREADY=0.
  - If any S_AXIS_TVALID, search ports grant+1, grant+2, ... modulo NM, wrapping. The first valid port found becomes the new grant and state goes to LOCKED.
  - Arbitration costs exactly one cycle and accepts no data.
  - If no port is valid, stay in IDLE and keep grant unchanged.
- State LOCKED:
  - S_AXIS_TREADY[grant] = !M_AXIS_TVALID || M_AXIS_TREADY. All other ready bits are 0.
  - On an accepted beat (S_AXIS_TVALID[grant] && S_AXIS_TREADY[grant]), load TDATA/TLAST into the output register and set M_AXIS_TVALID=1.
  - If the accepted beat has TLAST=1, go to IDLE next cycle.
- Output register:
  - If M_AXIS_TVALID && M_AXIS_TREADY with no new beat loaded, clear M_AXIS_TVALID.
  - Load and drain in the same cycle gives back-to-back throughput of 1 beat/cycle within a packet.
  - While M_AXIS_TVALID && !M_AXIS_TREADY, TDATA and TLAST hold stable.
- Latency: an accepted input beat appears on M one cycle later.
- Inter-packet gap: at least 1 cycle (the IDLE arbitration cycle).
- Fairness: after a packet from port k, port k has lowest priority. A port that stays valid waits at most NM-1 packets.
- Single-beat packet (TVALID and TLAST on the first beat): LOCKED for exactly one cycle if the output is free.
- A granted source that drops TVALID mid-packet does not release the grant. The arbiter waits indefinitely; only TLAST releases.
- Never assert more than one S_AXIS_TREADY bit; never assert any ready in IDLE.
- Index arithmetic: grant+i is computed in LGNM+1 bits and wrapped with a compare-subtract against NM. This is correct for non-power-of-2 NM.

Optional Feature:
- Macro: AXIS_RR_ARBITER_TID_EN.
- Defined:
  - Adds output port M_AXIS_TID, width LGNM, registered alongside TDATA. It carries the grant index of the source that produced the beat.
  - Resets to 0 and holds stable under backpressure.
- Undefined: the port does not exist, and the grant index is internal only.

Test Plan:
- Port 2 only sends a 3-beat packet A0..A2 (TLAST on A2), M_AXIS_TREADY=1 → after 1 arbitration cycle, M carries A0,A1,A2 on consecutive cycles, TLAST only on A2, then IDLE.
- All 4 ports continuously valid with 1-beat packets after reset → output source order 0,1,2,3,0,1,...; with TID_EN, M_AXIS_TID follows that sequence.
- Ports 1 and 3 valid, current grant 3, 2-beat packets → port 1 is served next, then 3; no beats are interleaved between packets.
- Port 0 sends data 0x1234, 0x5678 with M_AXIS_TREADY held low for 4 cycles → M_AXIS_TDATA=0x1234 stays stable, S_AXIS_TREADY[0]=0 while the output is full, and 0x5678 follows the cycle after ready rises.
- Granted port drops TVALID for 5 cycles mid-packet while other ports are valid → no other port receives TREADY; the packet completes once TVALID returns.
- Assert S_AXI_ARESETN=0 mid-packet, asynchronously between clock edges → M_AXIS_TVALID and all S_AXIS_TREADY go low immediately; after release, the first packet is granted to port 0.

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// Stream bundle for axis_rr_arbiter: NM input lanes merged onto one output lane.
// With AXIS_RR_ARBITER_TID_EN defined, the output also carries the source index M_AXIS_TID.
interface axis_rr_arbiter_if #(
    parameter int C_AXIS_DATA_WIDTH = 16,
    parameter int NM                = 4
);
    localparam int LGNM = $clog2(NM);

    logic [NM-1:0]                   S_AXIS_TVALID;
    logic [NM-1:0]                   S_AXIS_TREADY;
    logic [NM*C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA;
    logic [NM-1:0]                   S_AXIS_TLAST;
    logic                            M_AXIS_TVALID;
    logic                            M_AXIS_TREADY;
    logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA;
    logic                            M_AXIS_TLAST;
`ifdef AXIS_RR_ARBITER_TID_EN
    logic [LGNM-1:0]                 M_AXIS_TID;
`endif

    // Arbiter side: consumes the input lanes, produces the merged lane.
    modport slave (
        input  S_AXIS_TVALID,
        input  S_AXIS_TDATA,
        input  S_AXIS_TLAST,
        output S_AXIS_TREADY,
        output M_AXIS_TVALID,
        output M_AXIS_TDATA,
        output M_AXIS_TLAST,
`ifdef AXIS_RR_ARBITER_TID_EN
        output M_AXIS_TID,
`endif
        input  M_AXIS_TREADY
    );

    // Environment side: drives the producers and the downstream ready.
    modport master (
        output S_AXIS_TVALID,
        output S_AXIS_TDATA,
        output S_AXIS_TLAST,
        input  S_AXIS_TREADY,
        input  M_AXIS_TVALID,
        input  M_AXIS_TDATA,
        input  M_AXIS_TLAST,
`ifdef AXIS_RR_ARBITER_TID_EN
        input  M_AXIS_TID,
`endif
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin merge of NM AXI-Stream inputs onto one registered output.
// Optional macro AXIS_RR_ARBITER_TID_EN adds M_AXIS_TID (grant index of each output beat).
module axis_rr_arbiter #(
    parameter int  C_AXIS_DATA_WIDTH = 16,
    parameter int  NM                = 4,
    localparam int LGNM              = $clog2(NM)
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    axis_rr_arbiter_if.slave axis
);
    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int IW = LGNM + 1;
    localparam logic [IW-1:0] NM_W = IW'(NM);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [LGNM-1:0]   r_grant;
    logic [LGNM-1:0]   w_grant_next;
    logic [LGNM-1:0]   w_pick;
    logic              w_found;
    logic [IW-1:0]     w_idx;
    logic [NM-1:0]     w_s_tready;
    logic              w_out_free;
    logic              w_accept;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic [DW-1:0]     w_sel_data;

    logic              r_vld_p1;
    logic [DW-1:0]     r_data_p1;
    logic              r_last_p1;
`ifdef AXIS_RR_ARBITER_TID_EN
    logic [LGNM-1:0]   r_tid_p1;
`endif

    // Rotating search starting just after the current grant; the wrap is a
    // compare-subtract so non-power-of-2 NM works.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_grant;
        w_idx   = '0;
        for (int i = 1; i <= NM; i++) begin
            w_idx = {1'b0, r_grant} + IW'(i);
            if (w_idx >= NM_W) begin
                w_idx = w_idx - NM_W;
            end
            if (!w_found && axis.S_AXIS_TVALID[w_idx[LGNM-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[LGNM-1:0];
            end
        end
    end

    assign w_out_free = !r_vld_p1 || axis.M_AXIS_TREADY;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_s_tready  = '0;
        for (int k = 0; k < NM; k++) begin
            if (r_grant == LGNM'(k)) begin
                w_sel_valid   = axis.S_AXIS_TVALID[k];
                w_sel_last    = axis.S_AXIS_TLAST[k];
                w_sel_data    = axis.S_AXIS_TDATA[k*DW +: DW];
                w_s_tready[k] = (r_state == LOCKED) && w_out_free;
            end
        end
    end

    assign w_accept = (r_state == LOCKED) && w_sel_valid && w_out_free;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next = LOCKED;
                    w_grant_next = w_pick;
                end
            end
            LOCKED: begin
                // Only TLAST releases the grant; a stalled source keeps it.
                if (w_accept && w_sel_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= IDLE;
            r_grant <= LGNM'(NM - 1);
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
        end
    end

    // ---- stage p1: output register ----
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_last_p1 <= 1'b0;
`ifdef AXIS_RR_ARBITER_TID_EN
            r_tid_p1  <= '0;
`endif
        end else if (w_accept) begin
            r_vld_p1  <= 1'b1;
            r_data_p1 <= w_sel_data;
            r_last_p1 <= w_sel_last;
`ifdef AXIS_RR_ARBITER_TID_EN
            r_tid_p1  <= r_grant;
`endif
        end else if (axis.M_AXIS_TREADY) begin
            r_vld_p1  <= 1'b0;
        end
    end

    assign axis.S_AXIS_TREADY = w_s_tready;
    assign axis.M_AXIS_TVALID = r_vld_p1;
    assign axis.M_AXIS_TDATA  = r_data_p1;
    assign axis.M_AXIS_TLAST  = r_last_p1;
`ifdef AXIS_RR_ARBITER_TID_EN
    assign axis.M_AXIS_TID    = r_tid_p1;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: queue-driven sources, a packet-level reference model
// checked every cycle, and directed scenarios with literal expected output sequences.
module tb_axis_rr_arbiter;
    localparam int NM = 4;
    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            stall;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axis_rr_arbiter_if #(.C_AXIS_DATA_WIDTH(DW), .NM(NM)) axis ();

    axis_rr_arbiter #(.C_AXIS_DATA_WIDTH(DW), .NM(NM)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .axis          (axis)
    );

    beat_t         srcq [NM][$];
    obs_t          olog [$];
    logic [NM-1:0] hs;
    int            cyc;
    int            n_tests;
    int            n_fail;

    // Reference model state: who owns the output, what sits in the output slot.
    logic          md_vld;
    logic [DW-1:0] md_data;
    logic          md_last;
    int            md_own;
    logic          md_own_v;
    int            md_last_srv;
`ifdef AXIS_RR_ARBITER_TID_EN
    int            md_tid;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_beat(input int port, input logic [DW-1:0] d, input logic l, input int st);
        beat_t b;
        b.data  = d;
        b.last  = l;
        b.stall = st;
        srcq[port].push_back(b);
    endtask

    function automatic logic all_empty();
        logic e;
        e = 1'b1;
        for (int k = 0; k < NM; k++) begin
            if (srcq[k].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_idle(input string nm, input int maxc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            @(negedge clk); #1;
            done = all_empty() && !axis.M_AXIS_TVALID && (axis.S_AXIS_TVALID == '0);
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: not idle after %0d cycles, required idle", nm, maxc);
        end
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [DW-1:0] d, input logic l);
        if (idx >= olog.size()) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: beat %0d missing, got %0d beats, expected data %0h", nm, idx, olog.size(), d);
        end else begin
            chk({nm, "_data"}, olog[idx].data, d);
            chk({nm, "_last"}, olog[idx].last, l);
        end
    endtask

    task automatic set_mready(input logic v);
        @(posedge clk); #1;
        axis.M_AXIS_TREADY = v;
        @(negedge clk); #1;
    endtask

    // Source drivers: each port presents the head of its queue, honouring stalls.
    beat_t drv_b;
    initial begin
        logic [NM-1:0]    v;
        logic [NM-1:0]    l;
        logic [NM*DW-1:0] d;
        cyc = 0;
        axis.S_AXIS_TVALID = '0;
        axis.S_AXIS_TLAST  = '0;
        axis.S_AXIS_TDATA  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            v = '0;
            l = '0;
            d = '0;
            for (int k = 0; k < NM; k++) begin
                if (hs[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
                if (srcq[k].size() > 0) begin
                    if (srcq[k][0].stall > 0) begin
                        drv_b = srcq[k].pop_front();
                        drv_b.stall = drv_b.stall - 1;
                        srcq[k].push_front(drv_b);
                    end else begin
                        v[k] = 1'b1;
                        l[k] = srcq[k][0].last;
                        d[k*DW +: DW] = srcq[k][0].data;
                    end
                end
            end
            axis.S_AXIS_TVALID = v;
            axis.S_AXIS_TLAST  = l;
            axis.S_AXIS_TDATA  = d;
        end
    end

    // Per-cycle compare against the model, then advance the model across the next edge.
    initial begin
        logic [NM-1:0] exp_rdy;
        logic          acc;
        logic          fnd;
        int            p;
        obs_t          ob;
        hs = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_m_tvalid", axis.M_AXIS_TVALID, 0);
                chk("rst_s_tready", axis.S_AXIS_TREADY, 0);
                chk("rst_m_tdata", axis.M_AXIS_TDATA, 0);
                chk("rst_m_tlast", axis.M_AXIS_TLAST, 0);
`ifdef AXIS_RR_ARBITER_TID_EN
                chk("rst_m_tid", axis.M_AXIS_TID, 0);
                md_tid = 0;
`endif
                md_vld = 1'b0;
                md_data = '0;
                md_last = 1'b0;
                md_own = 0;
                md_own_v = 1'b0;
                md_last_srv = NM - 1;
                hs = '0;
            end else begin
                exp_rdy = '0;
                if (md_own_v && (!md_vld || axis.M_AXIS_TREADY)) exp_rdy[md_own] = 1'b1;
                chk("s_tready", axis.S_AXIS_TREADY, exp_rdy);
                chk("m_tvalid", axis.M_AXIS_TVALID, md_vld);
                if (md_vld) begin
                    chk("m_tdata", axis.M_AXIS_TDATA, md_data);
                    chk("m_tlast", axis.M_AXIS_TLAST, md_last);
`ifdef AXIS_RR_ARBITER_TID_EN
                    chk("m_tid", axis.M_AXIS_TID, md_tid);
`endif
                end
                if (axis.M_AXIS_TVALID && axis.M_AXIS_TREADY) begin
                    ob.data = axis.M_AXIS_TDATA;
                    ob.last = axis.M_AXIS_TLAST;
                    ob.cyc  = cyc;
                    olog.push_back(ob);
                end
                hs = axis.S_AXIS_TVALID & axis.S_AXIS_TREADY;

                acc = md_own_v && exp_rdy[md_own] && axis.S_AXIS_TVALID[md_own];
                if (acc) begin
                    md_vld  = 1'b1;
                    md_data = axis.S_AXIS_TDATA[md_own*DW +: DW];
                    md_last = axis.S_AXIS_TLAST[md_own];
`ifdef AXIS_RR_ARBITER_TID_EN
                    md_tid  = md_own;
`endif
                end else if (axis.M_AXIS_TREADY) begin
                    md_vld = 1'b0;
                end

                if (!md_own_v) begin
                    fnd = 1'b0;
                    for (int i = 1; i <= NM; i++) begin
                        p = (md_last_srv + i) % NM;
                        if (!fnd && axis.S_AXIS_TVALID[p]) begin
                            fnd = 1'b1;
                            md_own = p;
                        end
                    end
                    md_own_v = fnd;
                end else if (acc && axis.S_AXIS_TLAST[md_own]) begin
                    md_own_v = 1'b0;
                    md_last_srv = md_own;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] exp_rr [8] = '{16'h0200, 16'h1200, 16'h2200, 16'h3200,
                                  16'h0201, 16'h1201, 16'h2201, 16'h3201};

    initial begin
        int c0;
        logic hit;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        axis.M_AXIS_TREADY = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // All four ports with two single-beat packets each, straight after reset.
        @(negedge clk); #1;
        olog.delete();
        for (int k = 0; k < NM; k++) begin
            push_beat(k, 16'((k << 12) | 16'h0200), 1'b1, 0);
            push_beat(k, 16'((k << 12) | 16'h0201), 1'b1, 0);
        end
        wait_idle("rr_idle", 200);
        chk("rr_count", olog.size(), 8);
        for (int i = 0; i < 8; i++) chk_log("rr_order", i, exp_rr[i], 1'b1);

        // Port 2 alone, three-beat packet.
        olog.delete();
        c0 = cyc;
        push_beat(2, 16'h2A00, 1'b0, 0);
        push_beat(2, 16'h2A01, 1'b0, 0);
        push_beat(2, 16'h2A02, 1'b1, 0);
        wait_idle("p2_idle", 100);
        chk_log("p2_b0", 0, 16'h2A00, 1'b0);
        chk_log("p2_b1", 1, 16'h2A01, 1'b0);
        chk_log("p2_b2", 2, 16'h2A02, 1'b1);
        if (olog.size() >= 3) begin
            chk("p2_latency", olog[0].cyc - c0, 3);
            chk("p2_gap01", olog[1].cyc - olog[0].cyc, 1);
            chk("p2_gap12", olog[2].cyc - olog[1].cyc, 1);
        end

        // Move grant to 3, then ports 1 and 3 compete with two-beat packets.
        push_beat(3, 16'h3300, 1'b1, 0);
        wait_idle("g3_idle", 100);
        olog.delete();
        push_beat(1, 16'h1100, 1'b0, 0);
        push_beat(1, 16'h1101, 1'b1, 0);
        push_beat(3, 16'h3310, 1'b0, 0);
        push_beat(3, 16'h3311, 1'b1, 0);
        wait_idle("p13_idle", 100);
        chk_log("p13_b0", 0, 16'h1100, 1'b0);
        chk_log("p13_b1", 1, 16'h1101, 1'b1);
        chk_log("p13_b2", 2, 16'h3310, 1'b0);
        chk_log("p13_b3", 3, 16'h3311, 1'b1);

        // Backpressure: output ready low while port 0 sends two beats.
        set_mready(1'b0);
        olog.delete();
        push_beat(0, 16'h1234, 1'b0, 0);
        push_beat(0, 16'h5678, 1'b1, 0);
        for (int i = 0; i < 20 && !axis.M_AXIS_TVALID; i++) begin
            @(negedge clk); #1;
        end
        chk("bp_valid_seen", axis.M_AXIS_TVALID, 1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_data", axis.M_AXIS_TDATA, 16'h1234);
            chk("bp_hold_last", axis.M_AXIS_TLAST, 0);
            chk("bp_s_tready0", axis.S_AXIS_TREADY, 0);
            @(negedge clk); #1;
        end
        set_mready(1'b1);
        wait_idle("bp_idle", 100);
        chk_log("bp_b0", 0, 16'h1234, 1'b0);
        chk_log("bp_b1", 1, 16'h5678, 1'b1);
        if (olog.size() >= 2) chk("bp_follow", olog[1].cyc - olog[0].cyc, 1);

        // Granted port 1 stalls mid-packet while the others wait.
        olog.delete();
        push_beat(1, 16'h1500, 1'b0, 0);
        push_beat(1, 16'h1501, 1'b0, 5);
        push_beat(1, 16'h1502, 1'b1, 0);
        push_beat(0, 16'h0500, 1'b1, 0);
        push_beat(2, 16'h2500, 1'b1, 0);
        push_beat(3, 16'h3500, 1'b1, 0);
        wait_idle("stall_idle", 200);
        chk_log("stall_b0", 0, 16'h1500, 1'b0);
        chk_log("stall_b1", 1, 16'h1501, 1'b0);
        chk_log("stall_b2", 2, 16'h1502, 1'b1);
        chk_log("stall_b3", 3, 16'h2500, 1'b1);
        chk_log("stall_b4", 4, 16'h3500, 1'b1);
        chk_log("stall_b5", 5, 16'h0500, 1'b1);
        if (olog.size() >= 2) chk("stall_gap", olog[1].cyc - olog[0].cyc, 6);

        // Asynchronous reset in the middle of a port 1 packet.
        olog.delete();
        push_beat(1, 16'h1600, 1'b0, 0);
        push_beat(1, 16'h1601, 1'b0, 0);
        push_beat(1, 16'h1602, 1'b0, 0);
        push_beat(1, 16'h1603, 1'b1, 0);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk); #1;
            hit = (olog.size() >= 2);
        end
        chk("arst_pkt_started", hit, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        for (int k = 0; k < NM; k++) srcq[k].delete();
        #1;
        chk("arst_m_tvalid_now", axis.M_AXIS_TVALID, 0);
        chk("arst_s_tready_now", axis.S_AXIS_TREADY, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        olog.delete();
        push_beat(0, 16'h0600, 1'b1, 0);
        push_beat(2, 16'h2600, 1'b1, 0);
        wait_idle("arst_idle", 100);
        chk_log("arst_first", 0, 16'h0600, 1'b1);
        chk_log("arst_second", 1, 16'h2600, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
